// File: rtl/mem_stall_ctrl_pkg.sv
// Shared CPU package: memory-stage FSM encoding and wait-timeout default.
package mem_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd200;

    // The wait expires on the last permitted BUSY cycle, not one after it.
    function automatic logic wait_expired(input logic [7:0] count, input logic [7:0] limit);
        return count == (limit - 8'd1);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// 8-bit saturating wait counter; clr has priority over en.
module mem_timeout_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] count
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_stall_ctrl.sv
// EX/MEM stall controller: launches one multi-cycle memory access at a time,
// stalls the pipeline until completion or timeout, and presents the result.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_en,
    input  logic        Mem_read,
    input  logic        Mem_write,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    input  logic        halt,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        stall,
    output logic [15:0] data_read,
    output logic        wb_valid,
    output logic        mem_misalign,
    output logic        timeout_err
);

    mem_state_e  state_q, state_d;
    logic        drop_q, drop_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        start;
    logic        ctr_clr;
    logic        ctr_en;
    logic [7:0]  wait_cnt;

    logic        req_c, wr_c, stall_c, wb_c, terr_c;

    mem_timeout_ctr u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .count (wait_cnt)
    );

    assign start = (state_q == IDLE) && Mem_en && (Mem_read || Mem_write) &&
                   !address[0] && !halt && !flush;

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ctr_clr = 1'b0;
        ctr_en  = 1'b0;
        req_c   = 1'b0;
        wr_c    = 1'b0;
        stall_c = 1'b0;
        wb_c    = 1'b0;
        terr_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    req_c   = 1'b1;
                    wr_c    = Mem_write;
                    stall_c = 1'b1;
                    wr_d    = Mem_write;
                    addr_d  = address;
                    wdata_d = write_data;
                    ctr_clr = 1'b1;
                    state_d = BUSY;
                end else begin
                    wb_c = !flush;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                wr_c    = wr_q;
                ctr_en  = !mem_done;
                if (flush) begin
                    drop_d = 1'b1;
                end
                // mem_done takes priority over an expiry in the same cycle.
                if (mem_done) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                end else if (wait_expired(wait_cnt, TIMEOUT)) begin
                    terr_c  = 1'b1;
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d = '0;
                    end
                end
            end
            DONE: begin
                wr_c    = wr_q;
                wb_c    = !drop_q;
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign mem_req      = req_c   && !rst;
    assign mem_wr       = wr_c    && !rst;
    assign stall        = stall_c && !rst;
    assign wb_valid     = wb_c    && !rst;
    assign timeout_err  = terr_c  && !rst;
    assign mem_misalign = Mem_en && address[0] && (state_q == IDLE) && !rst;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign data_read    = rdata_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_stall_ctrl;

    localparam int TB_TIMEOUT = 200;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        halt;
        logic        flush;
        logic [15:0] rdata;
        logic        done;
    } in_t;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic        stall;
        logic        wb;
        logic        mis;
        logic        terr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] dr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        Mem_en, Mem_read, Mem_write, halt, flush, mem_done;
    logic [15:0] address, write_data, mem_rdata;
    logic        mem_req, mem_wr, stall, wb_valid, mem_misalign, timeout_err;
    logic [15:0] mem_addr, mem_wdata, data_read;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.TIMEOUT(8'd200)) dut (
        .clk          (clk),
        .rst          (rst),
        .Mem_en       (Mem_en),
        .Mem_read     (Mem_read),
        .Mem_write    (Mem_write),
        .address      (address),
        .write_data   (write_data),
        .halt         (halt),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .stall        (stall),
        .data_read    (data_read),
        .wb_valid     (wb_valid),
        .mem_misalign (mem_misalign),
        .timeout_err  (timeout_err)
    );

    function automatic in_t mk_in(logic en, logic rd, logic wr, logic [15:0] a, logic [15:0] wd,
                                  logic h, logic f, logic [15:0] rdat, logic d);
        in_t v;
        v = '{rst: 1'b0, en: en, rd: rd, wr: wr, addr: a, wdata: wd,
              halt: h, flush: f, rdata: rdat, done: d};
        return v;
    endfunction

    function automatic out_t mk_out(logic rq, logic w, logic s, logic wb, logic m, logic te,
                                    logic [15:0] a, logic [15:0] wd, logic [15:0] d);
        out_t o;
        o = '{req: rq, wr: w, stall: s, wb: wb, mis: m, terr: te, addr: a, wdata: wd, dr: d};
        return o;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input out_t e);
        chk({tag, ".mem_req"},      {15'd0, mem_req},      {15'd0, e.req});
        chk({tag, ".mem_wr"},       {15'd0, mem_wr},       {15'd0, e.wr});
        chk({tag, ".stall"},        {15'd0, stall},        {15'd0, e.stall});
        chk({tag, ".wb_valid"},     {15'd0, wb_valid},     {15'd0, e.wb});
        chk({tag, ".mem_misalign"}, {15'd0, mem_misalign}, {15'd0, e.mis});
        chk({tag, ".timeout_err"},  {15'd0, timeout_err},  {15'd0, e.terr});
        chk({tag, ".mem_addr"},     mem_addr,              e.addr);
        chk({tag, ".mem_wdata"},    mem_wdata,             e.wdata);
        chk({tag, ".data_read"},    data_read,             e.dr);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 2ns later.
    task automatic apply(input in_t v);
        @(negedge clk);
        rst        = v.rst;
        Mem_en     = v.en;
        Mem_read   = v.rd;
        Mem_write  = v.wr;
        address    = v.addr;
        write_data = v.wdata;
        halt       = v.halt;
        flush      = v.flush;
        mem_rdata  = v.rdata;
        mem_done   = v.done;
        #2;
    endtask

    // Reference model: an outstanding transaction with a wait-cycle count,
    // followed by a single result-presentation cycle.
    bit          m_pending;
    bit          m_present;
    int          m_waited;
    bit          m_drop;
    bit          m_is_wr;
    logic [15:0] m_addr, m_wdata, m_data;

    task automatic model_reset();
        m_pending = 0;
        m_present = 0;
        m_waited  = 0;
        m_drop    = 0;
        m_is_wr   = 0;
        m_addr    = '0;
        m_wdata   = '0;
        m_data    = '0;
    endtask

    function automatic bit model_launch(in_t v);
        return !m_pending && !m_present && v.en && (v.rd || v.wr) &&
               !v.addr[0] && !v.halt && !v.flush;
    endfunction

    function automatic out_t model_out(in_t v);
        out_t o;
        bit   idle;
        bit   go;
        o = '0;
        if (v.rst) return o;
        idle    = !m_pending && !m_present;
        go      = model_launch(v);
        o.req   = go;
        o.stall = go || m_pending;
        o.mis   = idle && v.en && v.addr[0];
        o.wr    = go ? v.wr : (idle ? 1'b0 : m_is_wr);
        o.terr  = m_pending && !v.done && (m_waited + 1 == TB_TIMEOUT);
        o.wb    = m_present ? !m_drop : (idle && !go && !v.flush);
        o.addr  = m_addr;
        o.wdata = m_wdata;
        o.dr    = m_data;
        return o;
    endfunction

    task automatic model_clock(in_t v);
        if (v.rst) begin
            model_reset();
        end else if (m_present) begin
            m_present = 0;
            m_drop    = 0;
        end else if (m_pending) begin
            if (v.flush) m_drop = 1;
            if (v.done) begin
                m_pending = 0;
                m_present = 1;
                if (!m_is_wr) m_data = v.rdata;
            end else if (m_waited + 1 == TB_TIMEOUT) begin
                m_pending = 0;
                m_present = 1;
                if (!m_is_wr) m_data = '0;
            end else begin
                m_waited++;
            end
        end else if (model_launch(v)) begin
            m_pending = 1;
            m_waited  = 0;
            m_is_wr   = v.wr;
            m_addr    = v.addr;
            m_wdata   = v.wdata;
        end
    endtask

    vec_t tbl[14];
    in_t  rdv, idle_in, rst_in;
    int   found;

    initial begin
        idle_in = mk_in(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0);
        rst_in  = idle_in;
        rst_in.rst = 1'b1;

        // Reset with a misaligned access on the inputs: everything must read 0.
        rst_in.en   = 1'b1;
        rst_in.rd   = 1'b1;
        rst_in.addr = 16'h0011;
        apply(rst_in);
        chk_all("reset", '0);
        apply(rst_in);
        chk_all("reset2", '0);

        tbl[0]  = '{mk_in(0,0,0,16'h0000,16'h0000,0,0,16'h0000,0), mk_out(0,0,0,1,0,0,16'h0000,16'h0000,16'h0000)};
        tbl[1]  = '{mk_in(1,1,0,16'h0010,16'h0000,0,0,16'h0000,0), mk_out(1,0,1,0,0,0,16'h0000,16'h0000,16'h0000)};
        tbl[2]  = '{mk_in(1,1,0,16'h0010,16'h0000,0,0,16'h0000,0), mk_out(0,0,1,0,0,0,16'h0010,16'h0000,16'h0000)};
        tbl[3]  = '{mk_in(1,1,0,16'h0010,16'h0000,0,0,16'h0000,0), mk_out(0,0,1,0,0,0,16'h0010,16'h0000,16'h0000)};
        tbl[4]  = '{mk_in(1,1,0,16'h0010,16'h0000,0,0,16'hBEEF,1), mk_out(0,0,1,0,0,0,16'h0010,16'h0000,16'h0000)};
        tbl[5]  = '{mk_in(1,1,0,16'h0010,16'h0000,0,0,16'h0000,0), mk_out(0,0,0,1,0,0,16'h0010,16'h0000,16'hBEEF)};
        tbl[6]  = '{mk_in(1,0,1,16'h0020,16'h1234,0,0,16'h0000,0), mk_out(1,1,1,0,0,0,16'h0010,16'h0000,16'hBEEF)};
        tbl[7]  = '{mk_in(1,0,1,16'h0020,16'h1234,0,0,16'h0000,0), mk_out(0,1,1,0,0,0,16'h0020,16'h1234,16'hBEEF)};
        tbl[8]  = '{mk_in(1,0,1,16'h0020,16'h1234,0,0,16'hDEAD,1), mk_out(0,1,1,0,0,0,16'h0020,16'h1234,16'hBEEF)};
        tbl[9]  = '{mk_in(0,0,0,16'h0000,16'h0000,0,0,16'h0000,0), mk_out(0,1,0,1,0,0,16'h0020,16'h1234,16'hBEEF)};
        tbl[10] = '{mk_in(1,1,0,16'h0011,16'h0000,0,0,16'h0000,0), mk_out(0,0,0,1,1,0,16'h0020,16'h1234,16'hBEEF)};
        tbl[11] = '{mk_in(1,1,0,16'h0030,16'h0000,1,0,16'h0000,0), mk_out(0,0,0,1,0,0,16'h0020,16'h1234,16'hBEEF)};
        tbl[12] = '{mk_in(1,1,0,16'h0030,16'h0000,0,1,16'h0000,0), mk_out(0,0,0,0,0,0,16'h0020,16'h1234,16'hBEEF)};
        tbl[13] = '{mk_in(1,1,0,16'h0031,16'h0000,0,1,16'h0000,0), mk_out(0,0,0,0,1,0,16'h0020,16'h1234,16'hBEEF)};

        foreach (tbl[r]) begin
            apply(tbl[r].i);
            chk_all($sformatf("row%0d", r), tbl[r].o);
        end

        // Read that never completes: expiry on the 200th BUSY cycle.
        rdv = mk_in(1, 1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 0);
        apply(rdv);
        chk("to.start_req", {15'd0, mem_req}, 16'd1);
        found = 0;
        for (int n = 1; n <= 300; n++) begin
            apply(rdv);
            if (timeout_err === 1'b1) begin
                found = n;
                chk("to.stall_at_expiry", {15'd0, stall}, 16'd1);
                break;
            end
            if (stall !== 1'b1) begin
                chk("to.stall_busy", {15'd0, stall}, 16'd1);
            end
        end
        chk("to.busy_cycles", found[15:0], 16'd200);
        apply(idle_in);
        chk("to.done_data", data_read, 16'h0000);
        chk("to.done_wb", {15'd0, wb_valid}, 16'd1);
        chk("to.done_terr", {15'd0, timeout_err}, 16'd0);
        chk("to.done_stall", {15'd0, stall}, 16'd0);

        // mem_done on the expiry cycle wins.
        rdv.addr = 16'h0042;
        apply(rdv);
        for (int n = 1; n < 200; n++) apply(rdv);
        rdv.done  = 1'b1;
        rdv.rdata = 16'h5A5A;
        apply(rdv);
        chk("coin.terr", {15'd0, timeout_err}, 16'd0);
        chk("coin.stall", {15'd0, stall}, 16'd1);
        apply(idle_in);
        chk("coin.data", data_read, 16'h5A5A);
        chk("coin.wb", {15'd0, wb_valid}, 16'd1);

        // Flush mid-access drops the writeback but the access completes.
        apply(mk_in(1, 1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 0));
        apply(mk_in(1, 1, 0, 16'h0050, 16'h0, 0, 1, 16'h0, 0));
        chk("flush.stall", {15'd0, stall}, 16'd1);
        apply(mk_in(1, 1, 0, 16'h0050, 16'h0, 0, 0, 16'h1111, 1));
        apply(mk_in(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0, 0));
        chk("flush.done_wb", {15'd0, wb_valid}, 16'd0);
        chk("flush.done_req", {15'd0, mem_req}, 16'd0);
        chk("flush.data", data_read, 16'h1111);
        apply(mk_in(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0, 0));
        chk("flush.next_req", {15'd0, mem_req}, 16'd1);
        apply(mk_in(1, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h2222, 1));
        chk("flush.next_addr", mem_addr, 16'h0060);
        apply(idle_in);
        chk("flush.next_wb", {15'd0, wb_valid}, 16'd1);
        chk("flush.next_data", data_read, 16'h2222);

        // Reset mid-access, then a stray mem_done.
        apply(mk_in(1, 1, 0, 16'h0070, 16'h0, 0, 0, 16'h0, 0));
        apply(mk_in(1, 1, 0, 16'h0070, 16'h0, 0, 0, 16'h0, 0));
        rdv = rst_in;
        rdv.addr = 16'h0070;
        apply(rdv);
        chk_all("rstbusy", '0);
        rdv.done  = 1'b1;
        rdv.rdata = 16'h7777;
        apply(rdv);
        chk_all("rstbusy.stray", '0);
        apply(mk_in(0, 0, 0, 16'h0, 16'h0, 0, 1, 16'h7777, 1));
        chk_all("rstbusy.after", '0);
        apply(idle_in);
        chk_all("rstbusy.idle", mk_out(0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0));
        apply(mk_in(1, 0, 1, 16'h0080, 16'hAAAA, 0, 0, 16'h0, 0));
        chk("rstbusy.restart_req", {15'd0, mem_req}, 16'd1);
        chk("rstbusy.restart_wr", {15'd0, mem_wr}, 16'd1);

        // Randomized traffic against the reference model.
        apply(rst_in);
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            in_t  v;
            out_t e;
            v.rst   = ($urandom_range(0, 149) == 0);
            v.en    = ($urandom_range(0, 3) != 0);
            v.rd    = 1'($urandom_range(0, 1));
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = 16'($urandom);
            v.addr[0] = ($urandom_range(0, 3) == 0);
            v.wdata = 16'($urandom);
            v.halt  = ($urandom_range(0, 7) == 0);
            v.flush = ($urandom_range(0, 7) == 0);
            v.rdata = 16'($urandom);
            v.done  = ($urandom_range(0, 3) == 0);
            apply(v);
            if (v.rst) model_reset();
            e = model_out(v);
            chk_all($sformatf("rand%0d", c), e);
            model_clock(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 SHALL have parameter TIMEOUT, default 8'd200: maximum number of cycles spent waiting for mem_done.
REQ-003 Ports, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset
- Mem_en  in  1  EX/MEM memory enable
- Mem_read  in  1  EX/MEM load
- Mem_write  in  1  EX/MEM store
- address  in  16  effective address
- write_data  in  16  store data
- halt  in  1  halt in flight; no access is started
- flush  in  1  squash the current instruction
- mem_req  out  1  one-cycle request to multi-cycle memory
- mem_wr  out  1  1 = write
- mem_addr  out  16  latched address
- mem_wdata  out  16  latched store data
- mem_rdata  in  16  memory read data
- mem_done  in  1  one-cycle completion pulse
- stall  out  1  hold IF..EX/MEM
- data_read  out  16  load result toward MEM/WB
- wb_valid  out  1  result valid this cycle
- mem_misalign  out  1  odd address with Mem_en
- timeout_err  out  1  one-cycle pulse on timeout

Function
REQ-004 FSM states: IDLE, BUSY, DONE.
REQ-005 IDLE starts an access when Mem_en & (Mem_read|Mem_write) & ~address[0] & ~halt & ~flush.
REQ-006 On start, in the same cycle: mem_req=1 and mem_wr=Mem_write. At the clock edge, address and write_data are latched into mem_addr and mem_wdata, the timeout counter is cleared, and the FSM goes to BUSY.
REQ-007 stall SHALL be combinational: 1 in the start cycle and in every BUSY cycle, 0 in IDLE without a start and 0 in DONE.
REQ-008 mem_req SHALL be high only in the start cycle and never in BUSY or DONE.
REQ-009 In BUSY, mem_done=1 moves the FSM to DONE. If the access is a read, mem_rdata is latched into data_read.
REQ-010 In BUSY without mem_done, the counter increments. When counter==TIMEOUT-1 without mem_done:
- timeout_err pulses for one cycle,
- data_read is set to 16'h0000,
- the FSM goes to DONE.
REQ-011 If mem_done and the timeout coincide, mem_done wins and timeout_err stays 0.
REQ-012 DONE lasts exactly one cycle, then returns to IDLE. DONE SHALL never start an access, because EX/MEM still holds the completed instruction.
REQ-013 wb_valid=1 in DONE unless the access was flushed.
REQ-014 In IDLE, an access with no start (not memory, flush, or halt) gives wb_valid=1 with data_read unchanged, except when flush=1, which gives wb_valid=0.
REQ-015 mem_misalign = Mem_en & address[0] & (state==IDLE). It is combinational, starts no access and causes no stall.
REQ-016 flush in BUSY SHALL set a drop flag: the access still completes, but wb_valid=0 in DONE. The drop flag clears on leaving DONE.
REQ-017 A write SHALL never modify data_read.
REQ-018 The counter is 8 bits and SHALL saturate, never wrap.

Reset
REQ-019 rst asynchronously forces: state=IDLE; mem_addr, mem_wdata and data_read = 16'h0000; counter=0; drop flag=0.
REQ-020 During reset, all outputs SHALL be 0.
REQ-021 Reset in BUSY abandons the access. A late mem_done after reset SHALL be ignored.

Structure
REQ-022 The state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the TIMEOUT default SHALL live in the shared CPU package.
REQ-023 The saturating counter SHALL be one sub-module, mem_timeout_ctr, with ports clk, rst, clr, en, and count[7:0].

Verification
REQ-024 Read of address 16'h0010, mem_done 3 cycles after mem_req with mem_rdata=16'hBEEF:
- stall high for 4 cycles,
- DONE follows with data_read=16'hBEEF and wb_valid=1.
REQ-025 Write of 16'h1234 to address 16'h0020: mem_wr=1, mem_addr=16'h0020, mem_wdata=16'h1234, and data_read is unchanged.
REQ-026 Mem_en with address=16'h0011: mem_misalign=1, with no mem_req and no stall.
REQ-027 Read with mem_done never asserted, TIMEOUT=200: timeout_err pulses exactly 200 BUSY cycles after entry, with data_read=0.
REQ-028 flush in BUSY, then mem_done: wb_valid=0 in DONE, and the next access starts normally.
REQ-029 rst asserted mid-BUSY, then a stray mem_done: the FSM stays IDLE and all outputs stay 0.
